// File: rtl/read_sel_seq.sv
// read_sel_seq: registered register-read select multiplexer for the multi-cycle datapath.
//
// A select is latched on sel_load and the chosen word is re-sampled every cycle while
// holding, so output_data follows the register file with one cycle of lag. Selects at or
// above NUM_IN produce a zero word and raise sel_err. An optional scan mode steps through
// every input once, for register-file dump/debug.
//
// Optional feature macro: READ_SEL_SCAN_EN
//   defined   - SCAN state, scan_start, scan_idx and scan_done are active.
//   undefined - no SCAN state, scan_start ignored, scan_idx and scan_done tied to 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   input_data   in   NUM_IN packed words, word i at [i*WORD_SIZE +: WORD_SIZE]
//   select       in   requested input index
//   sel_load     in   latch select this cycle
//   clear        in   synchronous return to IDLE, clears outputs
//   scan_start   in   begin a scan of all inputs
//   output_data  out  registered selected word
//   valid        out  output_data is meaningful
//   sel_err      out  latched select was out of range
//   scan_idx     out  index presented during scan
//   scan_done    out  one-cycle pulse with the last scan word
module read_sel_seq #(
    parameter int unsigned WORD_SIZE = 5,
    parameter int unsigned NUM_IN    = 3,
    parameter int unsigned SEL_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN*WORD_SIZE-1:0] input_data,
    input  logic [SEL_W-1:0]            select,
    input  logic                        sel_load,
    input  logic                        clear,
    input  logic                        scan_start,
    output logic [WORD_SIZE-1:0]        output_data,
    output logic                        valid,
    output logic                        sel_err,
    output logic [SEL_W-1:0]            scan_idx,
    output logic                        scan_done
);

    localparam logic [SEL_W:0] NumInW = (SEL_W + 1)'(NUM_IN);

`ifdef READ_SEL_SCAN_EN
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_IN - 1);
    typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;
`else
    typedef enum logic {StIdle, StHold} state_e;
`endif

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [WORD_SIZE-1:0]   out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

`ifdef READ_SEL_SCAN_EN
    logic [SEL_W-1:0]       idx_q, idx_d;
    logic                   done_q, done_d;
    logic [SEL_W-1:0]       nxt_idx;
`else
    logic                   unused_scan_start;
    assign unused_scan_start = scan_start;
`endif

    // Word mux; indices at or above NUM_IN yield zero.
    function automatic logic [WORD_SIZE-1:0] pick(input logic [NUM_IN*WORD_SIZE-1:0] data,
                                                  input logic [SEL_W-1:0] idx);
        logic [WORD_SIZE-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (idx == SEL_W'(i)) begin
                w = data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
        return w;
    endfunction

    function automatic logic out_of_range(input logic [SEL_W-1:0] idx);
        return {1'b0, idx} >= NumInW;
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
`ifdef READ_SEL_SCAN_EN
        idx_d   = idx_q;
        done_d  = 1'b0;
        nxt_idx = idx_q + 1'b1;
`endif

        if (clear) begin
            state_d = StIdle;
            valid_d = 1'b0;
            out_d   = '0;
            err_d   = 1'b0;
`ifdef READ_SEL_SCAN_EN
            idx_d   = '0;
`endif
        end
`ifdef READ_SEL_SCAN_EN
        // scan_start outranks sel_load but is ignored once a scan is running.
        else if (scan_start && (state_q != StScan)) begin
            state_d = StScan;
            idx_d   = '0;
            out_d   = pick(input_data, '0);
            valid_d = 1'b1;
            err_d   = 1'b0;
            done_d  = (LastIdx == '0);
        end
`endif
        else begin
            unique case (state_q)
                StIdle, StHold: begin
                    if (sel_load) begin
                        // New word shows up right after the load edge, so no valid gap.
                        sel_d   = select;
                        state_d = StHold;
                        out_d   = pick(input_data, select);
                        valid_d = 1'b1;
                        err_d   = out_of_range(select);
                    end else if (state_q == StHold) begin
                        out_d   = pick(input_data, sel_q);
                        valid_d = 1'b1;
                        err_d   = out_of_range(sel_q);
                    end else begin
                        valid_d = 1'b0;
                    end
                end
`ifdef READ_SEL_SCAN_EN
                StScan: begin
                    err_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        // Scan ends in IDLE; sel_q is untouched but HOLD is not resumed.
                        state_d = StIdle;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d   = nxt_idx;
                        out_d   = pick(input_data, nxt_idx);
                        valid_d = 1'b1;
                        done_d  = (nxt_idx == LastIdx);
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef READ_SEL_SCAN_EN
            idx_q   <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef READ_SEL_SCAN_EN
            idx_q   <= idx_d;
            done_q  <= done_d;
`endif
        end
    end

    assign output_data = out_q;
    assign valid       = valid_q;
    assign sel_err     = err_q;
`ifdef READ_SEL_SCAN_EN
    assign scan_idx    = idx_q;
    assign scan_done   = done_q;
`else
    assign scan_idx    = '0;
    assign scan_done   = 1'b0;
`endif

endmodule

// File: tb/tb_read_sel_seq.sv
// Bench for read_sel_seq: directed vector table, hand-written reset sequences and a
// randomized run checked against a behavioural model.
module tb_read_sel_seq;

    localparam int WS = 5;
    localparam int NI = 3;
    localparam int SW = 2;
`ifdef READ_SEL_SCAN_EN
    localparam bit ScanEn = 1'b1;
`else
    localparam bit ScanEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI*WS-1:0]  input_data;
    logic [SW-1:0]     select;
    logic              sel_load;
    logic              clear;
    logic              scan_start;
    logic [WS-1:0]     output_data;
    logic              valid;
    logic              sel_err;
    logic [SW-1:0]     scan_idx;
    logic              scan_done;

    int n_cmp = 0;
    int n_bad = 0;

    read_sel_seq #(.WORD_SIZE(WS), .NUM_IN(NI), .SEL_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_data  (input_data),
        .select      (select),
        .sel_load    (sel_load),
        .clear       (clear),
        .scan_start  (scan_start),
        .output_data (output_data),
        .valid       (valid),
        .sel_err     (sel_err),
        .scan_idx    (scan_idx),
        .scan_done   (scan_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = idle, 1 = holding a select, 2 = scanning.
    int m_mode, m_sel, m_out, m_valid, m_err, m_idx, m_done;

    function automatic int word_of(input logic [NI*WS-1:0] d, input int i);
        return int'((d >> (i * WS)) & ((1 << WS) - 1));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_out = 0; m_valid = 0; m_err = 0; m_idx = 0; m_done = 0;
    endtask

    task automatic model_present(input int s);
        if (s >= NI) begin
            m_out = 0; m_err = 1;
        end else begin
            m_out = word_of(input_data, s); m_err = 0;
        end
        m_valid = 1;
    endtask

    task automatic model_step();
        m_done = 0;
        if (clear) begin
            m_mode = 0; m_out = 0; m_valid = 0; m_err = 0; m_idx = 0;
        end else if (ScanEn && scan_start && m_mode != 2) begin
            m_mode = 2; m_idx = 0; m_out = word_of(input_data, 0); m_valid = 1; m_err = 0;
            m_done = (NI == 1) ? 1 : 0;
        end else if (m_mode == 2) begin
            if (m_idx == NI - 1) begin
                m_mode = 0; m_valid = 0; m_idx = 0;
            end else begin
                m_idx = m_idx + 1;
                m_out = word_of(input_data, m_idx);
                m_done = (m_idx == NI - 1) ? 1 : 0;
            end
        end else if (sel_load) begin
            m_sel = int'(select); m_mode = 1;
            model_present(m_sel);
        end else if (m_mode == 1) begin
            model_present(m_sel);
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},   int'(output_data), m_out);
        chk({tag, ".valid"}, int'(valid),       m_valid);
        chk({tag, ".err"},   int'(sel_err),     m_err);
        chk({tag, ".idx"},   int'(scan_idx),    ScanEn ? m_idx : 0);
        chk({tag, ".done"},  int'(scan_done),   ScanEn ? m_done : 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out"},   int'(output_data), 0);
        chk({tag, ".valid"}, int'(valid),       0);
        chk({tag, ".err"},   int'(sel_err),     0);
        chk({tag, ".idx"},   int'(scan_idx),    0);
        chk({tag, ".done"},  int'(scan_done),   0);
    endtask

    // Apply inputs away from the edge, clock once, advance the model, settle.
    task automatic cycle(input logic [NI*WS-1:0] d, input logic [SW-1:0] s,
                         input logic ld, input logic cl, input logic sc);
        input_data = d; select = s; sel_load = ld; clear = cl; scan_start = sc;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic [NI*WS-1:0] d;
        logic [SW-1:0]    s;
        logic             ld, cl, sc;
        int               e_out, e_valid, e_err, e_idx, e_done;
    } vec_t;

    localparam logic [NI*WS-1:0] D0 = {5'h03, 5'h02, 5'h01};
    localparam logic [NI*WS-1:0] D1 = {5'h1F, 5'h02, 5'h01};

    function automatic vec_t mk(input logic [NI*WS-1:0] d, input int s, input int ld,
                                input int cl, input int sc, input int eo, input int ev,
                                input int ee, input int ei, input int ed);
        vec_t v;
        v.d = d; v.s = SW'(s); v.ld = ld[0]; v.cl = cl[0]; v.sc = sc[0];
        v.e_out = eo; v.e_valid = ev; v.e_err = ee; v.e_idx = ei; v.e_done = ed;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        //            data sel ld cl sc  out  v  e idx done
        tbl[0]  = mk(D0, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0);
        tbl[1]  = mk(D0, 2, 1, 0, 0, 5'h03, 1, 0, 0, 0);
        tbl[2]  = mk(D0, 0, 0, 0, 0, 5'h03, 1, 0, 0, 0);
        tbl[3]  = mk(D1, 0, 0, 0, 0, 5'h1F, 1, 0, 0, 0);
        tbl[4]  = mk(D1, 1, 1, 0, 0, 5'h02, 1, 0, 0, 0);
        tbl[5]  = mk(D1, 3, 1, 0, 0, 5'h00, 1, 1, 0, 0);
        tbl[6]  = mk(D1, 0, 0, 0, 0, 5'h00, 1, 1, 0, 0);
        tbl[7]  = mk(D1, 0, 1, 0, 0, 5'h01, 1, 0, 0, 0);
        tbl[8]  = mk(D0, 2, 1, 1, 1, 5'h00, 0, 0, 0, 0);
        tbl[9]  = mk(D0, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0);
        tbl[10] = mk(D0, 1, 1, 0, 0, 5'h02, 1, 0, 0, 0);
        if (ScanEn) begin
            tbl[11] = mk(D0, 0, 0, 0, 1, 5'h01, 1, 0, 0, 0);
            tbl[12] = mk(D0, 2, 1, 0, 0, 5'h02, 1, 0, 1, 0);
            tbl[13] = mk(D0, 0, 0, 0, 1, 5'h03, 1, 0, 2, 1);
            tbl[14] = mk(D0, 0, 0, 0, 0, 5'h03, 0, 0, 0, 0);
            tbl[15] = mk(D0, 0, 0, 0, 0, 5'h03, 0, 0, 0, 0);
        end else begin
            tbl[11] = mk(D0, 0, 0, 0, 1, 5'h02, 1, 0, 0, 0);
            tbl[12] = mk(D0, 2, 1, 0, 0, 5'h03, 1, 0, 0, 0);
            tbl[13] = mk(D0, 0, 0, 0, 1, 5'h03, 1, 0, 0, 0);
            tbl[14] = mk(D0, 3, 0, 0, 1, 5'h03, 1, 0, 0, 0);
            tbl[15] = mk(D0, 0, 0, 0, 0, 5'h03, 1, 0, 0, 0);
        end

        // Reset held for three cycles with inputs present.
        rst_n = 1'b0;
        input_data = D0; select = '0; sel_load = 1'b0; clear = 1'b0; scan_start = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero($sformatf("reset%0d", i));
        end
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].d, tbl[i].s, tbl[i].ld, tbl[i].cl, tbl[i].sc);
            chk($sformatf("vec%0d.out", i),   int'(output_data), tbl[i].e_out);
            chk($sformatf("vec%0d.valid", i), int'(valid),       tbl[i].e_valid);
            chk($sformatf("vec%0d.err", i),   int'(sel_err),     tbl[i].e_err);
            chk($sformatf("vec%0d.idx", i),   int'(scan_idx),    tbl[i].e_idx);
            chk($sformatf("vec%0d.done", i),  int'(scan_done),   tbl[i].e_done);
        end

        // Out-of-range hold followed by scan_start: scan clears sel_err, otherwise it stays.
        cycle(D1, 3, 1'b1, 1'b0, 1'b0);
        chk_model("oor_load");
        cycle(D1, 0, 1'b0, 1'b0, 1'b1);
        chk("oor_scan.err", int'(sel_err), ScanEn ? 0 : 1);
        chk_model("oor_scan");

        // Asynchronous reset in the middle of a scan (or of a hold without the scan build).
        cycle(D0, 1, 1'b0, 1'b1, 1'b0);
        cycle(D0, 1, 1'b1, 1'b0, 1'b0);
        cycle(D0, 0, 1'b0, 1'b0, 1'b1);
        cycle(D0, 0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst.idx", int'(scan_idx), ScanEn ? 1 : 0);
        chk("pre_rst.out", int'(output_data), 5'h02);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(D0, 0, 1'b0, 1'b0, 1'b0);
        chk_zero("post_rst");

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [NI*WS-1:0] d;
            logic [SW-1:0]    s;
            logic             ld, cl, sc;
            d  = NI*WS'($urandom);
            s  = SW'($urandom_range(0, (1 << SW) - 1));
            ld = ($urandom_range(0, 99) < 30);
            cl = ($urandom_range(0, 99) < 5);
            sc = ($urandom_range(0, 99) < 12);
            cycle(d, s, ld, cl, sc);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
